// File: rtl/traffic_phase_scheduler.sv
// Traffic phase scheduler: sequences main-road, cross-road and pedestrian
// phases from a tick-driven timer, with emergency pre-emption and a
// flashing fallback mode selected by the switch input.
module traffic_phase_scheduler #(
    parameter int T_MAIN_MIN = 8,
    parameter int T_CROSS    = 6,
    parameter int T_YELLOW   = 3,
    parameter int T_ALLRED   = 1,
    parameter int T_WALK     = 5,
    parameter int TW         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       switch,
    input  logic       tick,
    input  logic       car_cross,
    input  logic       ped_req,
    input  logic       emergency,
    output logic [2:0] light_mainRoad,
    output logic [2:0] light_crossRoad,
    output logic       walk,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        MAIN_G   = 4'd0,
        MAIN_Y   = 4'd1,
        ALL_R1   = 4'd2,
        CROSS_G  = 4'd3,
        CROSS_Y  = 4'd4,
        ALL_R2   = 4'd5,
        PED_WALK = 4'd6,
        EMERG    = 4'd7,
        FLASH    = 4'd8
    } state_t;

    // Timer load values: a phase of N ticks counts N-1 down to 0.
    localparam logic [TW-1:0] L_MAIN   = TW'(T_MAIN_MIN - 1);
    localparam logic [TW-1:0] L_CROSS  = TW'(T_CROSS - 1);
    localparam logic [TW-1:0] L_YELLOW = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] L_ALLRED = TW'(T_ALLRED - 1);
    localparam logic [TW-1:0] L_WALK   = TW'(T_WALK - 1);

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic          r_crossQ;
    logic          r_pedQ;
    logic          r_blink;
    logic [2:0]    r_lightMain;
    logic [2:0]    r_lightCross;
    logic          r_walk;
    logic [3:0]    r_stateO;

    state_t        w_nextState;
    logic          w_expiry;
    logic          w_stateChange;
    logic [TW-1:0] w_nextTimer;
    logic          w_nextCrossQ;
    logic          w_nextPedQ;
    logic          w_nextBlink;
    logic [2:0]    w_nextMain;
    logic [2:0]    w_nextCross;
    logic          w_nextWalk;

    // Duration (minus one) loaded into the timer when a state is entered.
    function automatic logic [TW-1:0] loadValue(input state_t s);
        logic [TW-1:0] v;
        case (s)
            MAIN_G:           v = L_MAIN;
            MAIN_Y, CROSS_Y:  v = L_YELLOW;
            ALL_R1, ALL_R2:   v = L_ALLRED;
            CROSS_G:          v = L_CROSS;
            PED_WALK:         v = L_WALK;
            default:          v = '0;
        endcase
        return v;
    endfunction

    assign w_expiry      = tick && (r_timer == '0);
    assign w_stateChange = (w_nextState != r_state);

    // Next-state selection: flashing mode first, then emergency, then timed moves.
    always_comb begin
        w_nextState = r_state;
        if (!switch) begin
            w_nextState = FLASH;
        end else begin
            case (r_state)
                MAIN_G: begin
                    if (emergency || (w_expiry && (r_crossQ || r_pedQ)))
                        w_nextState = MAIN_Y;
                end
                MAIN_Y: begin
                    if (w_expiry)
                        w_nextState = emergency ? EMERG : ALL_R1;
                end
                ALL_R1: begin
                    if (emergency)
                        w_nextState = EMERG;
                    else if (w_expiry)
                        w_nextState = r_crossQ ? CROSS_G : PED_WALK;
                end
                CROSS_G: begin
                    if (emergency || w_expiry)
                        w_nextState = CROSS_Y;
                end
                CROSS_Y: begin
                    if (w_expiry)
                        w_nextState = emergency ? EMERG : ALL_R2;
                end
                ALL_R2: begin
                    if (emergency)
                        w_nextState = EMERG;
                    else if (w_expiry)
                        w_nextState = r_pedQ ? PED_WALK : MAIN_G;
                end
                PED_WALK: begin
                    if (emergency)
                        w_nextState = EMERG;
                    else if (w_expiry)
                        w_nextState = MAIN_G;
                end
                EMERG: begin
                    if (!emergency)
                        w_nextState = ALL_R2;
                end
                FLASH: begin
                    w_nextState = ALL_R2;
                end
                default: begin
                    w_nextState = ALL_R2;
                end
            endcase
        end
    end

    // Timer reloads on every state entry, otherwise counts down on ticks and sticks at zero.
    always_comb begin
        w_nextTimer = r_timer;
        if (w_stateChange)
            w_nextTimer = loadValue(w_nextState);
        else if (tick && (r_timer != '0))
            w_nextTimer = r_timer - TW'(1);
    end

    // Request latches: a new request always wins over the clear on service entry.
    always_comb begin
        w_nextCrossQ = r_crossQ;
        w_nextPedQ   = r_pedQ;
        if (w_stateChange && (w_nextState == CROSS_G))
            w_nextCrossQ = 1'b0;
        if (w_stateChange && (w_nextState == PED_WALK))
            w_nextPedQ = 1'b0;
        if (car_cross)
            w_nextCrossQ = 1'b1;
        if (ped_req)
            w_nextPedQ = 1'b1;
    end

    // Blink phase restarts lit on FLASH entry and toggles on each tick while flashing.
    always_comb begin
        w_nextBlink = 1'b1;
        if ((w_nextState == FLASH) && (r_state == FLASH))
            w_nextBlink = r_blink ^ tick;
    end

    // Lamp pattern for the state about to be entered, so outputs track the state register.
    always_comb begin
        w_nextMain  = LAMP_RED;
        w_nextCross = LAMP_RED;
        w_nextWalk  = 1'b0;
        case (w_nextState)
            MAIN_G:   w_nextMain  = LAMP_GRN;
            MAIN_Y:   w_nextMain  = LAMP_YEL;
            CROSS_G:  w_nextCross = LAMP_GRN;
            CROSS_Y:  w_nextCross = LAMP_YEL;
            PED_WALK: w_nextWalk  = 1'b1;
            FLASH: begin
                w_nextMain  = w_nextBlink ? LAMP_YEL : LAMP_OFF;
                w_nextCross = w_nextBlink ? LAMP_YEL : LAMP_OFF;
            end
            default: begin
                w_nextMain  = LAMP_RED;
                w_nextCross = LAMP_RED;
            end
        endcase
    end

    // State, timer, latches and registered outputs; reset parks everything in all-red.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ALL_R2;
            r_timer      <= L_ALLRED;
            r_crossQ     <= 1'b0;
            r_pedQ       <= 1'b0;
            r_blink      <= 1'b1;
            r_lightMain  <= LAMP_RED;
            r_lightCross <= LAMP_RED;
            r_walk       <= 1'b0;
            r_stateO     <= ALL_R2;
        end else begin
            r_state      <= w_nextState;
            r_timer      <= w_nextTimer;
            r_crossQ     <= w_nextCrossQ;
            r_pedQ       <= w_nextPedQ;
            r_blink      <= w_nextBlink;
            r_lightMain  <= w_nextMain;
            r_lightCross <= w_nextCross;
            r_walk       <= w_nextWalk;
            r_stateO     <= w_nextState;
        end
    end

    assign light_mainRoad  = r_lightMain;
    assign light_crossRoad = r_lightCross;
    assign walk            = r_walk;
    assign state_o         = r_stateO;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Testbench for traffic_phase_scheduler: directed vector table, hand-written
// emergency / flash / tick-gating sequences, and a randomized run compared
// against a phase-level reference model.
module tb_traffic_phase_scheduler;

    localparam int T_MAIN_MIN = 8;
    localparam int T_CROSS    = 6;
    localparam int T_YELLOW   = 3;
    localparam int T_ALLRED   = 1;
    localparam int T_WALK     = 5;
    localparam int TW         = 8;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw;
    logic       tick;
    logic       carCross;
    logic       pedReq;
    logic       emergency;
    logic [2:0] lightMain;
    logic [2:0] lightCross;
    logic       walk;
    logic [3:0] stateO;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        logic       sw;
        logic       tick;
        logic       car;
        logic       ped;
        logic       em;
        logic [2:0] expMain;
        logic [2:0] expCross;
        logic       expWalk;
        logic [3:0] expState;
    } vector_t;

    vector_t vectors[$];

    // Reference model: phase number, ticks elapsed in the phase, pending requests, blink lamp.
    int   mPhase;
    int   mElapsed;
    logic mCross;
    logic mPed;
    logic mLit;

    logic rSw;
    logic rEm;

    traffic_phase_scheduler #(
        .T_MAIN_MIN(T_MAIN_MIN),
        .T_CROSS   (T_CROSS),
        .T_YELLOW  (T_YELLOW),
        .T_ALLRED  (T_ALLRED),
        .T_WALK    (T_WALK),
        .TW        (TW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .switch         (sw),
        .tick           (tick),
        .car_cross      (carCross),
        .ped_req        (pedReq),
        .emergency      (emergency),
        .light_mainRoad (lightMain),
        .light_crossRoad(lightCross),
        .walk           (walk),
        .state_o        (stateO)
    );

    always #5 clk = ~clk;

    // Safety net so the run always ends even if something stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    function automatic int phaseTicks(input int p);
        case (p)
            0:       return T_MAIN_MIN;
            1, 4:    return T_YELLOW;
            2, 5:    return T_ALLRED;
            3:       return T_CROSS;
            6:       return T_WALK;
            default: return 1;
        endcase
    endfunction

    task automatic modelReset();
        mPhase   = 5;
        mElapsed = 0;
        mCross   = 1'b0;
        mPed     = 1'b0;
        mLit     = 1'b1;
    endtask

    task automatic modelStep(input logic s, input logic t, input logic c, input logic p, input logic e);
        int   nxt;
        logic done;
        done = t && (mElapsed == phaseTicks(mPhase) - 1);
        nxt  = mPhase;
        if (!s) nxt = 8;
        else begin
            case (mPhase)
                0: if (e || (done && (mCross || mPed))) nxt = 1;
                1: if (done) nxt = e ? 7 : 2;
                2: if (e) nxt = 7; else if (done) nxt = mCross ? 3 : 6;
                3: if (e || done) nxt = 4;
                4: if (done) nxt = e ? 7 : 5;
                5: if (e) nxt = 7; else if (done) nxt = mPed ? 6 : 0;
                6: if (e) nxt = 7; else if (done) nxt = 0;
                7: if (!e) nxt = 5;
                default: nxt = 5;
            endcase
        end
        mCross = c || (mCross && !(nxt == 3 && mPhase != 3));
        mPed   = p || (mPed && !(nxt == 6 && mPhase != 6));
        if (nxt == 8 && mPhase == 8) begin
            if (t) mLit = !mLit;
        end else begin
            mLit = 1'b1;
        end
        if (nxt != mPhase) mElapsed = 0;
        else if (t && mElapsed < phaseTicks(mPhase) - 1) mElapsed = mElapsed + 1;
        mPhase = nxt;
    endtask

    function automatic logic [2:0] modelMain();
        if (mPhase == 8) return mLit ? YEL : OFF;
        if (mPhase == 0) return GRN;
        if (mPhase == 1) return YEL;
        return RED;
    endfunction

    function automatic logic [2:0] modelCross();
        if (mPhase == 8) return mLit ? YEL : OFF;
        if (mPhase == 3) return GRN;
        if (mPhase == 4) return YEL;
        return RED;
    endfunction

    // Inputs change at the falling edge; returns at the next falling edge for sampling.
    task automatic applyStimulus(input logic s, input logic t, input logic c, input logic p, input logic e);
        sw        = s;
        tick      = t;
        carCross  = c;
        pedReq    = p;
        emergency = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [2:0] eMain, input logic [2:0] eCross,
                               input logic eWalk, input logic [3:0] eState);
        nChecks++;
        if (lightMain === eMain && lightCross === eCross && walk === eWalk && stateO === eState)
            nPass++;
        else
            $display("[TB] FAIL %s: main/cross/walk/state got %b/%b/%b/%0d, expected %b/%b/%b/%0d",
                     name, lightMain, lightCross, walk, stateO, eMain, eCross, eWalk, eState);
    endtask

    task automatic runExpect(input string name, input int n, input logic s, input logic t, input logic c,
                             input logic p, input logic e, input logic [2:0] eMain, input logic [2:0] eCross,
                             input logic eWalk, input logic [3:0] eState);
        for (int i = 0; i < n; i++) begin
            applyStimulus(s, t, c, p, e);
            checkOutput($sformatf("%s[%0d]", name, i), eMain, eCross, eWalk, eState);
        end
    endtask

    // Called just after a falling edge: asserts reset between clock edges and releases it a cycle later.
    task automatic pulseReset(input string name);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput(name, RED, RED, 1'b0, 4'd5);
        @(negedge clk);
        checkOutput({name, "_held"}, RED, RED, 1'b0, 4'd5);
        rst_n = 1'b1;
    endtask

    task automatic addRows(input int n, input logic c, input logic p, input logic [2:0] eMain,
                           input logic [2:0] eCross, input logic eWalk, input logic [3:0] eState);
        vector_t v;
        for (int i = 0; i < n; i++) begin
            v.sw       = 1'b1;
            v.tick     = 1'b1;
            v.car      = (i == 0) ? c : 1'b0;
            v.ped      = (i == 0) ? p : 1'b0;
            v.em       = 1'b0;
            v.expMain  = eMain;
            v.expCross = eCross;
            v.expWalk  = eWalk;
            v.expState = eState;
            vectors.push_back(v);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        sw        = 1'b1;
        tick      = 1'b1;
        carCross  = 1'b0;
        pedReq    = 1'b0;
        emergency = 1'b0;
        rSw       = 1'b1;
        rEm       = 1'b0;
        modelReset();

        // Cross service after reset: car pulse in the second main-green cycle
        addRows(2,  1'b0, 1'b0, GRN, RED, 1'b0, 4'd0);
        addRows(6,  1'b1, 1'b0, GRN, RED, 1'b0, 4'd0);
        addRows(3,  1'b0, 1'b0, YEL, RED, 1'b0, 4'd1);
        addRows(1,  1'b0, 1'b0, RED, RED, 1'b0, 4'd2);
        addRows(6,  1'b0, 1'b0, RED, GRN, 1'b0, 4'd3);
        addRows(3,  1'b0, 1'b0, RED, YEL, 1'b0, 4'd4);
        addRows(1,  1'b0, 1'b0, RED, RED, 1'b0, 4'd5);
        addRows(11, 1'b0, 1'b0, GRN, RED, 1'b0, 4'd0);
        // Cross plus pedestrian requested together while main green sits expired
        addRows(1,  1'b1, 1'b1, GRN, RED, 1'b0, 4'd0);
        addRows(3,  1'b0, 1'b0, YEL, RED, 1'b0, 4'd1);
        addRows(1,  1'b0, 1'b0, RED, RED, 1'b0, 4'd2);
        addRows(6,  1'b0, 1'b0, RED, GRN, 1'b0, 4'd3);
        addRows(3,  1'b0, 1'b0, RED, YEL, 1'b0, 4'd4);
        addRows(1,  1'b0, 1'b0, RED, RED, 1'b0, 4'd5);
        addRows(5,  1'b0, 1'b0, RED, RED, 1'b1, 4'd6);
        addRows(10, 1'b0, 1'b0, GRN, RED, 1'b0, 4'd0);

        @(negedge clk);
        checkOutput("reset", RED, RED, 1'b0, 4'd5);
        rst_n = 1'b1;

        for (int i = 0; i < vectors.size(); i++) begin
            applyStimulus(vectors[i].sw, vectors[i].tick, vectors[i].car, vectors[i].ped, vectors[i].em);
            checkOutput($sformatf("vec[%0d]", i), vectors[i].expMain, vectors[i].expCross,
                        vectors[i].expWalk, vectors[i].expState);
        end

        // Emergency raised in the second cross-green cycle
        runExpect("emgCar",      1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, GRN, RED, 1'b0, 4'd0);
        runExpect("emgMainY",    3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, YEL, RED, 1'b0, 4'd1);
        runExpect("emgAllR1",    1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, RED, RED, 1'b0, 4'd2);
        runExpect("emgCrossG",   2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, RED, GRN, 1'b0, 4'd3);
        runExpect("emgCrossY",   3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, RED, YEL, 1'b0, 4'd4);
        runExpect("emgHold",     6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, RED, RED, 1'b0, 4'd7);
        runExpect("emgExit",     1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, RED, RED, 1'b0, 4'd5);
        runExpect("emgBackMain", 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, GRN, RED, 1'b0, 4'd0);

        // Emergency leaves main green without a tick; the yellow itself still needs ticks
        runExpect("emgNoTick",   3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, YEL, RED, 1'b0, 4'd1);
        runExpect("emgYelTick",  2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, YEL, RED, 1'b0, 4'd1);
        runExpect("emgEnter2",   1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, RED, RED, 1'b0, 4'd7);
        runExpect("emgExit2",    1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, RED, RED, 1'b0, 4'd5);
        runExpect("emgMain2",    1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, GRN, RED, 1'b0, 4'd0);

        // Flashing mode with a tick every second cycle, then reset in the middle of it
        runExpect("flashEnter",   1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, YEL, YEL, 1'b0, 4'd8);
        runExpect("flashTick1",   1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, OFF, OFF, 1'b0, 4'd8);
        runExpect("flashIdle1",   1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OFF, OFF, 1'b0, 4'd8);
        runExpect("flashTick2",   1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, YEL, YEL, 1'b0, 4'd8);
        runExpect("flashIdle2",   1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, YEL, YEL, 1'b0, 4'd8);
        runExpect("flashEmg",     1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, OFF, OFF, 1'b0, 4'd8);
        runExpect("flashExit",    1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, RED, RED, 1'b0, 4'd5);
        runExpect("flashMain",    1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, GRN, RED, 1'b0, 4'd0);
        runExpect("flashReenter", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, YEL, YEL, 1'b0, 4'd8);
        runExpect("flashTick3",   1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, OFF, OFF, 1'b0, 4'd8);
        sw = 1'b1;
        pulseReset("flashReset");

        // Idle after reset release: main green held indefinitely
        runExpect("idle", 20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, GRN, RED, 1'b0, 4'd0);

        // Tick gating during cross yellow, with a pedestrian press while frozen
        runExpect("tgCar",       1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, GRN, RED, 1'b0, 4'd0);
        runExpect("tgMainY",     3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, YEL, RED, 1'b0, 4'd1);
        runExpect("tgAllR1",     1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, RED, RED, 1'b0, 4'd2);
        runExpect("tgCrossG",    6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, RED, GRN, 1'b0, 4'd3);
        runExpect("tgCrossY",    2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, RED, YEL, 1'b0, 4'd4);
        runExpect("tgFrozenPed", 1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, RED, YEL, 1'b0, 4'd4);
        runExpect("tgFrozen",    19, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RED, YEL, 1'b0, 4'd4);
        runExpect("tgResume",    1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, RED, YEL, 1'b0, 4'd4);
        runExpect("tgAllR2",     1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, RED, RED, 1'b0, 4'd5);
        runExpect("tgWalk",      5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, RED, RED, 1'b1, 4'd6);
        runExpect("tgMain",      2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, GRN, RED, 1'b0, 4'd0);

        // Randomized traffic against the reference model
        pulseReset("rndReset");
        for (int i = 0; i < 4000; i++) begin
            logic rTick;
            logic rCar;
            logic rPed;
            if (rSw) rSw = ($urandom_range(0, 149) != 0);
            else     rSw = ($urandom_range(0, 7) == 0);
            if (rEm) rEm = ($urandom_range(0, 14) != 0);
            else     rEm = ($urandom_range(0, 59) == 0);
            rTick = ($urandom_range(0, 3) != 0);
            rCar  = ($urandom_range(0, 19) == 0);
            rPed  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 799) == 0)
                pulseReset($sformatf("rndReset%0d", i));
            applyStimulus(rSw, rTick, rCar, rPed, rEm);
            modelStep(rSw, rTick, rCar, rPed, rEm);
            checkOutput($sformatf("rnd[%0d]", i), modelMain(), modelCross(),
                        (mPhase == 6) ? 1'b1 : 1'b0, 4'(mPhase));
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
  T_MAIN_MIN, 8, minimum main-road green, in ticks
  T_CROSS, 6, cross-road green, in ticks
  T_YELLOW, 3, yellow on either road, in ticks
  T_ALLRED, 1, all-red clearance, in ticks
  T_WALK, 5, pedestrian walk, in ticks
  TW, 8, timer width
  All T_* values are 1..2^TW-1.
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
  clk, in, 1, single clock; all state changes on its rising edge
  rst_n, in, 1, asynchronous, active-low reset
  switch, in, 1, 1 = normal operation, 0 = flashing mode
  tick, in, 1, one-cycle timing strobe; all timers count only on tick=1
  car_cross, in, 1, cross-road vehicle sensor (level or pulse)
  ped_req, in, 1, pedestrian button (level or pulse)
  emergency, in, 1, pre-emption request (level)
  light_mainRoad, out, 3, main-road lamps {red, yellow, green}
  light_crossRoad, out, 3, cross-road lamps {red, yellow, green}
  walk, out, 1, pedestrian walk lamp
  state_o, out, 4, current state encoding (REQ-004)

Function
REQ-003 Outputs SHALL be registered: one-hot lamp codes are 100=red, 010=yellow, 001=green, and 000=dark (FLASH only).
REQ-004 The states SHALL be MAIN_G=0, MAIN_Y=1, ALL_R1=2, CROSS_G=3, CROSS_Y=4, ALL_R2=5, PED_WALK=6, EMERG=7, FLASH=8.
REQ-005 The lamp outputs per state (main/cross/walk) SHALL be:
  MAIN_G: 001/100/0
  MAIN_Y: 010/100/0
  CROSS_G: 100/001/0
  CROSS_Y: 100/010/0
  ALL_R1, ALL_R2, EMERG: 100/100/0
  PED_WALK: 100/100/1
  FLASH: both roads show 010 or 000 per the blink phase, walk=0.
REQ-006 Timer on every state entry:
  - Load duration-1.
  - On each tick=1 cycle with timer!=0, decrement.
  - An expiry is a tick=1 cycle with timer==0.
  - tick=0 freezes the timer and all timed transitions.
REQ-007 Request latches:
  - cross_q sets on car_cross=1 and clears on entry to CROSS_G.
  - ped_q sets on ped_req=1 and clears on entry to PED_WALK.
  - Set and clear in the same cycle: set wins.
REQ-008 Timed transitions:
  - MAIN_G -> MAIN_Y on expiry only if cross_q|ped_q; otherwise hold in MAIN_G with the timer held at 0.
  - MAIN_Y -> ALL_R1 on expiry.
  - ALL_R1 -> CROSS_G if cross_q, else PED_WALK.
  - CROSS_G -> CROSS_Y on expiry.
  - CROSS_Y -> ALL_R2 on expiry.
  - ALL_R2 -> PED_WALK if ped_q, else MAIN_G.
  - PED_WALK -> MAIN_G on expiry.
REQ-009 Durations: MAIN_G uses T_MAIN_MIN, MAIN_Y and CROSS_Y use T_YELLOW, ALL_R1 and ALL_R2 use T_ALLRED, CROSS_G uses T_CROSS, PED_WALK uses T_WALK.
REQ-010 Emergency=1 handling, independent of tick:
  - In MAIN_G or CROSS_G, go to the same road's yellow on the next edge.
  - The yellow completes its full T_YELLOW, then goes to EMERG.
  - In ALL_R1, ALL_R2 or PED_WALK, go to EMERG on the next edge.
REQ-011 EMERG SHALL hold while emergency=1; when emergency=0, go to ALL_R2 on the next edge.
REQ-012 In EMERG, request latches SHALL keep setting and SHALL NOT clear.
REQ-013 switch=0 SHALL force FLASH on the next edge from any state, with priority over emergency.
REQ-014 In FLASH, the blink phase SHALL start at 010 and toggle on each tick.
REQ-015 On leaving FLASH (switch=1), go to ALL_R2 with a fresh T_ALLRED.
REQ-016 Only one transition SHALL occur per clock, and the state register SHALL never hold an undefined encoding; encodings 9..15 recover to ALL_R2.

Reset
REQ-017 While rst_n=0, the module SHALL immediately force state ALL_R2 with timer=T_ALLRED-1 and cross_q=ped_q=0.
REQ-018 While rst_n=0, outputs SHALL be light_mainRoad=100, light_crossRoad=100, walk=0, state_o=5, and the blink phase SHALL be 010.
REQ-019 Reset asserted mid-operation, including in FLASH or EMERG, SHALL abort all activity with the same values as REQ-017 and REQ-018.
REQ-020 After reset deassertion, operation SHALL resume from ALL_R2.

Verification
All scenarios use default parameters and tick=1 every cycle unless stated.
REQ-021 Idle: release reset with switch=1 and no requests -> 100/100 for 1 cycle, then 001/100 held indefinitely with state_o=0.
REQ-022 Cross service: pulse car_cross 1 cycle during MAIN_G cycle 2 -> sequence below, then MAIN_G; cross_q=0 from CROSS_G entry.
  - 001/100 for 8 cycles
  - 010/100 for 3 cycles
  - 100/100 for 1 cycle
  - 100/001 for 6 cycles
  - 100/010 for 3 cycles
  - 100/100 for 1 cycle
REQ-023 Cross plus pedestrian: pulse car_cross and ped_req together -> cross sequence per REQ-022, then walk=1 for 5 cycles, then 001/100.
REQ-024 Emergency: raise emergency at CROSS_G cycle 2 -> 100/010 on the next cycle for 3 cycles, then state_o=7 with 100/100 held; drop emergency -> 1 all-red cycle, then 001/100.
REQ-025 Flash and reset: switch=0 in MAIN_G with tick every 2nd cycle -> state_o=8 next cycle, lamps toggle 010/010 <-> 000/000 on each tick; rst_n=0 mid-flash -> 100/100 immediately.
REQ-026 Tick gating: tick=0 for 20 cycles during CROSS_Y -> state and lamps frozen; the remaining yellow completes after tick resumes.
